// File: rtl/duck_pkg.sv
// rtl/duck_pkg.sv - shared duck sprite geometry and controller state type
package duck_pkg;

    // Sprite box, shared with the renderer
    localparam int DUCK_WIDTH  = 64;
    localparam int DUCK_HEIGHT = 48;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef enum logic [2:0] {
        IDLE,
        FLY,
        HIT,
        FALL,
        ESCAPE
    } duck_state_t;

endpackage

// File: rtl/duck_ctl_lfsr16.sv
// rtl/duck_ctl_lfsr16.sv - 16-bit Fibonacci LFSR, taps 16,14,13,11, advances every cycle
// Ports: clk, rst (sync, active-high, loads SEED), q (current LFSR value)
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= SEED;
        end else begin
            q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
        end
    end

endmodule

// File: rtl/duck_ctl.sv
// rtl/duck_ctl.sv - duck spawn, per-frame flight with edge bounce, shot hit test, hit/fall/escape sequencing
// Ports: clk, rst (sync, active-high); new_frame, start, shot, shot_x, shot_y in;
//        duck_x, duck_y, duck_show, duck_hit to the renderer; duck_shot, duck_escaped,
//        duck_done one-cycle event pulses; busy high outside IDLE. All outputs registered.
module duck_ctl
    import duck_pkg::*;
#(
    parameter int          SPEED      = 2,
    parameter int          FALL_SPEED = 4,
    parameter int          ESC_SPEED  = 4,
    parameter int          FLY_FRAMES = 600,
    parameter int          HIT_FRAMES = 30,
    parameter int          X_MAX      = 576,
    parameter int          Y_MIN      = 16,
    parameter int          SPAWN_Y    = 320,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       new_frame,
    input  logic       start,
    input  logic       shot,
    input  logic [9:0] shot_x,
    input  logic [9:0] shot_y,
    output logic [9:0] duck_x,
    output logic [9:0] duck_y,
    output logic       duck_show,
    output logic       duck_hit,
    output logic       duck_shot,
    output logic       duck_escaped,
    output logic       duck_done,
    output logic       busy
);

    // 11-bit working widths so edge sums and differences never wrap
    localparam logic [10:0] SPEED_W   = 11'(SPEED);
    localparam logic [10:0] FALL_W    = 11'(FALL_SPEED);
    localparam logic [10:0] ESC_W     = 11'(ESC_SPEED);
    localparam logic [10:0] X_MAX_W   = 11'(X_MAX);
    localparam logic [10:0] Y_MIN_W   = 11'(Y_MIN);
    localparam logic [10:0] SPAWN_Y_W = 11'(SPAWN_Y);
    localparam logic [10:0] WIDTH_W   = 11'(DUCK_WIDTH);
    localparam logic [10:0] HEIGHT_W  = 11'(DUCK_HEIGHT);
    localparam logic [9:0]  X_MAX_10  = 10'(X_MAX);
    localparam logic [9:0]  SPAWN_10  = 10'(SPAWN_Y);
    localparam logic [15:0] FLY_LAST  = 16'(FLY_FRAMES - 1);
    localparam logic [15:0] HIT_LAST  = 16'(HIT_FRAMES - 1);

    duck_state_t state;
    logic        dir_x;   // 1 = moving right
    logic        dir_up;  // 1 = moving up (y decreasing)
    logic [15:0] ctr;
    logic [15:0] lfsr_q;

    logic [10:0] x_w, y_w, sx_w, sy_w;
    logic [10:0] fly_x, fly_y;
    logic        fly_dir_x, fly_dir_up;
    logic        shot_in_box;
    logic [9:0]  spawn_x;
    logic        unused_lfsr;

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    // Only the low 11 bits feed spawn position and direction
    assign unused_lfsr = ^lfsr_q[15:11];

    assign x_w  = {1'b0, duck_x};
    assign y_w  = {1'b0, duck_y};
    assign sx_w = {1'b0, shot_x};
    assign sy_w = {1'b0, shot_y};

    assign shot_in_box = (sx_w >= x_w) && (sx_w < x_w + WIDTH_W) &&
                         (sy_w >= y_w) && (sy_w < y_w + HEIGHT_W);

    assign spawn_x = (lfsr_q[9:0] > X_MAX_10) ? X_MAX_10 : lfsr_q[9:0];

    // Next flight position: clamp at the limit and reverse on the axis that hits it
    always_comb begin
        fly_x      = x_w;
        fly_y      = y_w;
        fly_dir_x  = dir_x;
        fly_dir_up = dir_up;
        if (dir_x) begin
            if (x_w + SPEED_W > X_MAX_W) begin
                fly_x     = X_MAX_W;
                fly_dir_x = 1'b0;
            end else begin
                fly_x = x_w + SPEED_W;
            end
        end else if (x_w < SPEED_W) begin
            fly_x     = '0;
            fly_dir_x = 1'b1;
        end else begin
            fly_x = x_w - SPEED_W;
        end
        if (dir_up) begin
            if (y_w <= Y_MIN_W + SPEED_W) begin
                fly_y      = Y_MIN_W;
                fly_dir_up = 1'b0;
            end else begin
                fly_y = y_w - SPEED_W;
            end
        end else if (y_w + SPEED_W >= SPAWN_Y_W) begin
            fly_y      = SPAWN_Y_W;
            fly_dir_up = 1'b1;
        end else begin
            fly_y = y_w + SPEED_W;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            duck_x       <= '0;
            duck_y       <= SPAWN_10;
            duck_show    <= 1'b0;
            duck_hit     <= 1'b0;
            duck_shot    <= 1'b0;
            duck_escaped <= 1'b0;
            duck_done    <= 1'b0;
            busy         <= 1'b0;
            dir_x        <= 1'b0;
            dir_up       <= 1'b1;
            ctr          <= '0;
        end else begin
            duck_shot    <= 1'b0;
            duck_escaped <= 1'b0;
            duck_done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        duck_x    <= spawn_x;
                        duck_y    <= SPAWN_10;
                        dir_x     <= lfsr_q[10];
                        dir_up    <= 1'b1;
                        ctr       <= '0;
                        duck_show <= 1'b1;
                        busy      <= 1'b1;
                        state     <= FLY;
                    end
                end
                FLY: begin
                    // A hit takes priority over the frame move and the escape timeout
                    if (shot && shot_in_box) begin
                        duck_hit  <= 1'b1;
                        duck_shot <= 1'b1;
                        ctr       <= '0;
                        state     <= HIT;
                    end else if (new_frame) begin
                        duck_x <= fly_x[9:0];
                        duck_y <= fly_y[9:0];
                        dir_x  <= fly_dir_x;
                        dir_up <= fly_dir_up;
                        if (ctr == FLY_LAST) begin
                            ctr   <= '0;
                            state <= ESCAPE;
                        end else begin
                            ctr <= ctr + 16'd1;
                        end
                    end
                end
                HIT: begin
                    if (new_frame) begin
                        if (ctr == HIT_LAST) begin
                            ctr   <= '0;
                            state <= FALL;
                        end else begin
                            ctr <= ctr + 16'd1;
                        end
                    end
                end
                FALL: begin
                    if (new_frame) begin
                        if (y_w + FALL_W >= SPAWN_Y_W) begin
                            duck_y    <= SPAWN_10;
                            duck_show <= 1'b0;
                            duck_hit  <= 1'b0;
                            duck_done <= 1'b1;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            duck_y <= duck_y + FALL_W[9:0];
                        end
                    end
                end
                ESCAPE: begin
                    if (new_frame) begin
                        if (y_w < ESC_W) begin
                            duck_y       <= '0;
                            duck_show    <= 1'b0;
                            duck_escaped <= 1'b1;
                            busy         <= 1'b0;
                            state        <= IDLE;
                        end else begin
                            duck_y <= duck_y - ESC_W[9:0];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
